// File: rtl/led_fade_pkg.sv
// rtl/led_fade_pkg.sv - shared types, defaults and ramp arithmetic for the LED fade scheduler
package led_fade_pkg;

    localparam int DEF_NUM_LEDS = 8;
    localparam int DEF_WIDTH    = 16;
    localparam int MAX_WIDTH    = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } fade_state_t;

    // One extra bit on the upward sum so level+step can never wrap past the target.
    function automatic logic [MAX_WIDTH-1:0] step_toward(
        input logic [MAX_WIDTH-1:0] level,
        input logic [MAX_WIDTH-1:0] target,
        input logic [MAX_WIDTH-1:0] step
    );
        logic [MAX_WIDTH:0]   sum;
        logic [MAX_WIDTH-1:0] result;
        sum    = {1'b0, level} + {1'b0, step};
        result = level;
        if (level < target) begin
            result = (sum >= {1'b0, target}) ? target : sum[MAX_WIDTH-1:0];
        end else if (level > target) begin
            result = ((level - target) <= step) ? target : (level - step);
        end
        return result;
    endfunction

endpackage

// File: rtl/led_fade_scheduler_if.sv
// rtl/led_fade_scheduler_if.sv - target-level write bus between host config logic and the scheduler
interface led_fade_scheduler_if
    import led_fade_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int WIDTH    = DEF_WIDTH
);
    localparam int ADDR_W = $clog2(NUM_LEDS);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/led_sd_channel.sv
// rtl/led_sd_channel.sv - first-order sigma-delta modulator driving one LED pin
module led_sd_channel
    import led_fade_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic             led
);

    logic [WIDTH:0] acc;

    // The carry out of the low WIDTH bits is the pulse; it is dropped before the next add.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[WIDTH-1:0]} + {1'b0, level};
        end
    end

    assign led = acc[WIDTH];

endmodule

// File: rtl/led_fade_scheduler.sv
// rtl/led_fade_scheduler.sv - periodic sweeps ramping each LED level toward its host-written target
module led_fade_scheduler
    import led_fade_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    led_fade_scheduler_if.slave  wr,
    input  logic [WIDTH-1:0]     step,
    input  logic [15:0]          rate_div,
    input  logic                 clr_overrun,
    output logic [NUM_LEDS-1:0]  led_out,
    output logic [NUM_LEDS-1:0]  at_target,
    output logic                 busy,
    output logic                 overrun
);

    localparam int                IDX_W    = $clog2(NUM_LEDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

    logic [WIDTH-1:0]     target [NUM_LEDS];
    logic [WIDTH-1:0]     level  [NUM_LEDS];
    logic [15:0]          count;
    logic                 tick;
    fade_state_t          state;
    logic [IDX_W-1:0]     idx;
    logic [MAX_WIDTH-1:0] stepped_unused_msbs;
    logic [WIDTH-1:0]     next_level;

    assign tick = (rate_div != 16'd0) && (count == rate_div - 16'd1);

    // Any count at or past the last slot restarts, so shrinking rate_div never runs out to 0xFFFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if ((rate_div == 16'd0) || (count >= rate_div - 16'd1)) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                target[i] <= '0;
            end
        end else if (wr.wr_en && (int'(wr.wr_addr) < NUM_LEDS)) begin
            target[wr.wr_addr] <= wr.wr_data;
        end
    end

    always_comb begin
        stepped_unused_msbs = step_toward(MAX_WIDTH'(level[idx]), MAX_WIDTH'(target[idx]),
                                          MAX_WIDTH'(step));
    end

    assign next_level = stepped_unused_msbs[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                level[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    level[idx] <= next_level;
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A tick landing mid-sweep is lost; flagging it takes priority over the host clear.
            if ((state == SWEEP) && tick) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < NUM_LEDS; c++) begin : g_chan
        assign at_target[c] = (level[c] == target[c]);

        led_sd_channel #(
            .WIDTH (WIDTH)
        ) u_sd (
            .clk   (clk),
            .reset (reset),
            .level (level[c]),
            .led   (led_out[c])
        );
    end

endmodule

// File: tb/tb_led_fade_scheduler.sv
// tb/tb_led_fade_scheduler.sv - scoreboard bench for led_fade_scheduler against a sweep-level model
module tb_led_fade_scheduler;

    localparam int N = 8;
    localparam int W = 16;

    typedef struct packed {
        logic [N-1:0][W-1:0] lvl;
        logic [N-1:0]        at;
        logic                ovr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  step = '0;
    logic [15:0]   rate_div = '0;
    logic          clr_overrun = 1'b0;
    logic [N-1:0]  led_out;
    logic [N-1:0]  at_target;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    led_fade_scheduler_if #(.NUM_LEDS(N), .WIDTH(W)) wr_if ();

    led_fade_scheduler #(.NUM_LEDS(N), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr_if),
        .step        (step),
        .rate_div    (rate_div),
        .clr_overrun (clr_overrun),
        .led_out     (led_out),
        .at_target   (at_target),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: prescaler period, sweep position and per-channel levels as plain integers.
    int   m_cnt = 0;
    int   m_pos = -1;
    bit   m_ovr = 1'b0;
    int   m_tgt [N];
    int   m_lvl [N];
    exp_t q [$];

    function automatic int approach(input int cur, input int tgt, input int stp);
        if (cur < tgt) return (tgt - cur <= stp) ? tgt : cur + stp;
        if (cur > tgt) return (cur - tgt <= stp) ? tgt : cur - stp;
        return cur;
    endfunction

    always @(posedge clk) begin
        bit   tk;
        bit   done;
        bit   sweeping;
        exp_t e;
        if (reset) begin
            m_cnt = 0;
            m_pos = -1;
            m_ovr = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_tgt[i] = 0;
                m_lvl[i] = 0;
            end
        end else begin
            tk       = (rate_div != 0) && (m_cnt == int'(rate_div) - 1);
            m_cnt    = (rate_div == 0 || tk || m_cnt >= int'(rate_div)) ? 0 : m_cnt + 1;
            sweeping = (m_pos >= 0);
            done     = 1'b0;
            if (sweeping) begin
                m_lvl[m_pos] = approach(m_lvl[m_pos], m_tgt[m_pos], int'(step));
                if (m_pos == N - 1) begin
                    done  = 1'b1;
                    m_pos = -1;
                end else begin
                    m_pos++;
                end
            end else if (tk) begin
                m_pos = 0;
            end
            if (sweeping && tk) m_ovr = 1'b1;
            else if (clr_overrun) m_ovr = 1'b0;
            if (wr_if.wr_en) m_tgt[wr_if.wr_addr] = int'(wr_if.wr_data);
            if (done) begin
                for (int i = 0; i < N; i++) begin
                    e.lvl[i] = W'(m_lvl[i]);
                    e.at[i]  = (m_lvl[i] == m_tgt[i]);
                end
                e.ovr = m_ovr;
                q.push_back(e);
            end
        end
    end

    // Monitor: each falling edge of busy marks a finished sweep to compare against the queue.
    logic prev_busy = 1'b0;
    int   run_len = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_busy = 1'b0;
            run_len   = 0;
        end else begin
            if (busy) run_len++;
            if (prev_busy && !busy) begin
                check("busy_len", run_len, N);
                run_len = 0;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sweep: got sweep end expected none");
                end else begin
                    e = q.pop_front();
                    for (int i = 0; i < N; i++) begin
                        check($sformatf("sweep_level[%0d]", i), dut.level[i], e.lvl[i]);
                    end
                    check("sweep_at_target", at_target, e.at);
                    check("sweep_overrun", overrun, e.ovr);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic write(input int addr, input int data);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_addr = 3'(addr);
        wr_if.wr_data = W'(data);
        @(negedge clk);
        wr_if.wr_en = 1'b0;
    endtask

    task automatic wait_sweeps(input int k, input int budget);
        int   seen = 0;
        int   t = 0;
        logic pb;
        pb = busy;
        while (seen < k && t < budget) begin
            @(negedge clk);
            t++;
            if (pb && !busy) seen++;
            pb = busy;
        end
        check("sweep_wait_budget", seen, k);
    endtask

    int busy_cycles;
    int dens [N];

    initial begin
        wr_if.wr_en   = 1'b0;
        wr_if.wr_addr = '0;
        wr_if.wr_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_led_out", led_out, 0);
        check("rst_at_target", at_target, 8'hFF);
        reset = 1'b0;

        // Upward ramp on channel 2.
        step = 16'h1000;
        rate_div = 16'd20;
        write(2, 16'h3000);
        wait_sweeps(3, 200);
        check("ramp_level2", dut.level[2], 16'h3000);
        check("ramp_at_target2", at_target[2], 1);

        // Saturating downward ramp on channel 5.
        step = 16'hFFFF;
        write(5, 16'hFFFF);
        wait_sweeps(1, 100);
        check("down_level5_top", dut.level[5], 16'hFFFF);
        step = 16'h8000;
        write(5, 16'h0005);
        wait_sweeps(1, 100);
        check("down_level5_mid", dut.level[5], 16'h7FFF);
        wait_sweeps(1, 100);
        check("down_level5_end", dut.level[5], 16'h0005);

        // Reset in the middle of a sweep.
        for (int t = 0; t < 100 && !busy; t++) @(negedge clk);
        check("reset_sweep_seen", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_led_out", led_out, 0);
        check("midrst_at_target", at_target, 8'hFF);
        check("midrst_level5", dut.level[5], 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Overrun with a tick every 4 cycles; clear held high must lose to the set.
        clr_overrun = 1'b1;
        rate_div = 16'd4;
        wait_sweeps(3, 100);
        check("ovr_set_wins", overrun, 1);
        rate_div = 16'd0;
        repeat (2) @(negedge clk);
        check("ovr_cleared", overrun, 0);
        clr_overrun = 1'b0;

        // Frozen prescaler: writes land, levels never move.
        busy_cycles = 0;
        for (int c = 0; c < 300; c++) begin
            wr_if.wr_en   = ($urandom_range(0, 1) == 0);
            wr_if.wr_addr = 3'($urandom_range(0, N - 1));
            wr_if.wr_data = W'($urandom);
            step = W'($urandom);
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        wr_if.wr_en = 1'b0;
        check("freeze_no_busy", busy_cycles, 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("freeze_level[%0d]", i), dut.level[i], m_lvl[i]);
        end

        // Write to channel 3 on the very cycle the sweep updates channel 3.
        write(3, 16'h0800);
        rate_div = 16'd20;
        step = 16'hFFFF;
        repeat (23) @(negedge clk);
        write(3, 16'h0100);
        wait_sweeps(1, 100);
        check("collide_old_target", dut.level[3], 16'h0800);
        check("collide_at_target3", at_target[3], 0);
        wait_sweeps(1, 100);
        check("collide_new_target", dut.level[3], 16'h0100);

        // Randomized traffic including rate_div changes below the running count.
        rate_div = 16'($urandom_range(10, 40));
        for (int c = 0; c < 3000; c++) begin
            wr_if.wr_en   = ($urandom_range(0, 3) == 0);
            wr_if.wr_addr = 3'($urandom_range(0, N - 1));
            wr_if.wr_data = W'($urandom);
            clr_overrun   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) rate_div = 16'($urandom_range(0, 40));
            if ($urandom_range(0, 99) == 0) step = W'($urandom);
            @(negedge clk);
        end
        wr_if.wr_en = 1'b0;
        clr_overrun = 1'b0;

        // Pulse density over one full accumulator period.
        rate_div = 16'd20;
        step = 16'hFFFF;
        write(0, 16'h4000);
        write(1, 16'h0000);
        write(2, 16'hFFFF);
        for (int i = 3; i < N; i++) write(i, int'($urandom_range(0, 16'hFFFF)));
        wait_sweeps(2, 200);
        rate_div = 16'd0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < N; i++) dens[i] = 0;
        repeat (65536) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) dens[i] += int'(led_out[i]);
        end
        check("density_ch0", dens[0], 16384);
        check("density_ch1", dens[1], 0);
        check("density_ch2", dens[2], 65535);
        for (int i = 3; i < N; i++) begin
            check($sformatf("density_ch%0d", i), dens[i], m_lvl[i]);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_fade_scheduler.md
Name: led_fade_scheduler

Overview:
- Owns a bank of LED sigma-delta drivers and sequences their brightness.
- Host writes per-channel target levels.
- A programmable tick prescaler triggers periodic sweeps. Each sweep visits every channel once, one channel per cycle, and moves that channel's current level toward its target by a global step.
- Sits between the host config/wire-in logic and the board LED pins.

Parameters:
- NUM_LEDS, 8, number of LED channels (≥2).
- WIDTH, 16, brightness/accumulator width in bits.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  one-cycle write strobe for a target level.
- wr_addr  in  clog2(NUM_LEDS)  channel index for the write.
- wr_data  in  WIDTH  new target level.
- step  in  WIDTH  ramp increment per sweep; 0 = levels hold.
- rate_div  in  16  ramp tick period in clk cycles; 0 = ramping frozen.
- clr_overrun  in  1  clears the sticky overrun flag.
- led_out  out  NUM_LEDS  per-channel sigma-delta pulse outputs.
- at_target  out  NUM_LEDS  level == target, per channel.
- busy  out  1  high while a sweep is in progress.
- overrun  out  1  sticky: a tick arrived during a sweep.

Behaviour:
- Reset values:
  - All targets, levels, accumulators, prescaler and channel index = 0.
  - State = IDLE.
  - led_out = 0, at_target = all ones (0 == 0), busy = 0, overrun = 0.
- Target write:
  - When wr_en is high, target[wr_addr] <= wr_data; the new value is visible the next cycle.
  - wr_addr ≥ NUM_LEDS is ignored.
  - Writes are accepted in every state.
- Prescaler:
  - If rate_div == 0: the counter holds at 0 and no tick is generated.
  - Otherwise the counter increments each cycle. When it reaches rate_div-1 it wraps to 0 and asserts tick for one cycle, giving a period of exactly rate_div cycles.
- FSM, IDLE:
  - busy = 0.
  - On tick: idx <= 0, go to SWEEP.
- FSM, SWEEP:
  - busy = 1.
  - Each cycle, update channel idx.
  - If idx == NUM_LEDS-1, return to IDLE next cycle; otherwise idx+1.
  - A sweep therefore lasts exactly NUM_LEDS cycles.
- Tick during SWEEP: the tick is dropped and overrun <= 1. overrun stays set until clr_overrun. If a tick and clr_overrun occur in the same cycle, set wins.
- Level update rule for channel c:
  - The update uses the registered target value from before any same-cycle write.
  - Compute in WIDTH+1 bits.
  - If level < target: level <= min(level+step, target).
  - If level > target: level <= (level-target ≤ step) ? target : level-step.
  - Equal: no change.
  - The result never overshoots and never wraps.
- at_target[c] is combinational: level[c] == target[c].
- Sigma-delta per channel:
  - acc is WIDTH+1 bits; each cycle acc <= {1'b0, acc[WIDTH-1:0]} + level.
  - led_out = acc[WIDTH], registered.
  - Pulse density = level / 2^WIDTH.
  - A level change affects led_out starting the cycle after the update.
- Reset mid-sweep: everything returns to the reset values immediately; no partial sweep resumes.
- Config changes:
  - step and rate_div are sampled live each cycle.
  - Changing rate_div below the current count causes the count to keep incrementing to 0xFFFF, then wrap. The implementation must instead reset the count to 0 whenever count ≥ rate_div.

Decomposition:
- Package led_fade_pkg holds:
  - the FSM state enum (IDLE, SWEEP);
  - default NUM_LEDS and WIDTH constants;
  - a function for the saturating step-toward-target.
- Sub-module led_sd_channel: one sigma-delta accumulator, ports clk, reset, level[WIDTH], led. It is instantiated NUM_LEDS times via generate.

Test Plan:
- Reset behaviour: assert reset for 3 cycles mid-sweep → busy=0, overrun=0, led_out=0, at_target=8'hFF within the same cycle as reset assertion.
- Upward ramp: rate_div=20, step=0x1000, write target[2]=0x3000 → level[2] reaches 0x1000, 0x2000, 0x3000 on three consecutive sweeps; at_target[2]=1 after the third; no overshoot.
- Saturating downward ramp: level[5]=0xFFFF, target 0x0005, step=0x8000 → levels 0x7FFF, then 0x0005; no underflow.
- Overrun: NUM_LEDS=8, rate_div=4 → overrun sets during the first sweep and busy stays high for exactly 8 cycles per sweep; clr_overrun together with a tick leaves overrun=1.
- Pulse density: target/level 0x4000 on channel 0, WIDTH=16 → led_out[0] high for exactly 16384 of 65536 cycles. Level 0 → led_out stays 0. Level 0xFFFF → 65535 highs per 65536 cycles.
- Freeze and write collision: with rate_div=0, no sweeps occur and levels hold. A write to channel 3 in the same cycle the sweep updates channel 3 → that update uses the old target, and the new target applies on the next sweep.
